// File: rtl/rtc_adj_ctrl.sv
// rtl/rtc_adj_ctrl.sv - rtc precise-adjustment step sequencer (optional RTC_ADJ_CTRL_ACC_EN)
module rtc_adj_ctrl #(
  parameter logic [7:0]  MAX_STEP_NS = 8'd4,
  parameter logic [31:0] STEP_GAP    = 32'd15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_mark,
  output logic        busy,
  output logic        done,
  output logic        adj_ld,
  output logic [31:0] adj_ld_data,
  output logic [39:0] period_adj,
  input  logic        adj_ld_done
`ifdef RTC_ADJ_CTRL_ACC_EN
  ,
  output logic [31:0] applied_ns
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  step_q, step_d;
  logic        adj_ld_q, adj_ld_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [7:0]  pa_ns_q, pa_ns_d;
  logic        done_q, done_d;
`ifdef RTC_ADJ_CTRL_ACC_EN
  logic [31:0] acc_q, acc_d;
`endif

  logic [31:0] rem_abs;
  logic [31:0] rem_sub;
  logic [7:0]  step_new;
  logic        sign_new;
  logic [31:0] rem_new;

  // Clamp a remaining magnitude to the per-step limit.
  function automatic logic [7:0] clamp_step(input logic [31:0] r);
    if (r >= {24'd0, MAX_STEP_NS}) clamp_step = MAX_STEP_NS;
    else                           clamp_step = r[7:0];
  endfunction

  // Next-state and step bookkeeping; step values are prepared on entry to LOAD so outputs are registered.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    rem_d     = rem_q;
    step_d    = step_q;
    adj_ld_d  = 1'b0;
    ld_data_d = ld_data_q;
    pa_ns_d   = pa_ns_q;
    done_d    = 1'b0;
`ifdef RTC_ADJ_CTRL_ACC_EN
    acc_d     = acc_q;
`endif
    // -2^31 negates to itself, which reads correctly as the unsigned magnitude 2^31.
    rem_abs   = req_offset[31] ? (~req_offset + 32'd1) : req_offset;
    rem_sub   = rem_q - {24'd0, step_q};
    sign_new  = sign_q;
    rem_new   = rem_sub;
    step_new  = clamp_step(rem_sub);

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          sign_d   = req_offset[31];
          rem_d    = rem_abs;
          sign_new = req_offset[31];
          rem_new  = rem_abs;
          step_new = clamp_step(rem_abs);
          if (rem_abs == 32'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            pa_ns_d = 8'd0;
          end else begin
            state_d   = S_LOAD;
            adj_ld_d  = 1'b1;
            step_d    = step_new;
            ld_data_d = req_mark;
            pa_ns_d   = sign_new ? (8'd0 - step_new) : step_new;
          end
        end
      end
      S_LOAD: begin
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // The rtc keeps adj_ld_done high for a couple of edges after the load strobe.
        if (!adj_ld_done) state_d = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (adj_ld_done) begin
          rem_d = rem_sub;
`ifdef RTC_ADJ_CTRL_ACC_EN
          acc_d = sign_q ? (acc_q - {24'd0, step_q}) : (acc_q + {24'd0, step_q});
`endif
          if (rem_new == 32'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            pa_ns_d = 8'd0;
          end else begin
            state_d   = S_LOAD;
            adj_ld_d  = 1'b1;
            step_d    = step_new;
            ld_data_d = STEP_GAP;
            pa_ns_d   = sign_new ? (8'd0 - step_new) : step_new;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      rem_q     <= 32'd0;
      step_q    <= 8'd0;
      adj_ld_q  <= 1'b0;
      ld_data_q <= 32'd0;
      pa_ns_q   <= 8'd0;
      done_q    <= 1'b0;
`ifdef RTC_ADJ_CTRL_ACC_EN
      acc_q     <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      adj_ld_q  <= adj_ld_d;
      ld_data_q <= ld_data_d;
      pa_ns_q   <= pa_ns_d;
      done_q    <= done_d;
`ifdef RTC_ADJ_CTRL_ACC_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign req_ready   = rst_n && (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign adj_ld      = adj_ld_q;
  assign adj_ld_data = ld_data_q;
  assign period_adj  = {pa_ns_q, 32'd0};
`ifdef RTC_ADJ_CTRL_ACC_EN
  assign applied_ns  = acc_q;
`endif

endmodule

// File: tb/tb_rtc_adj_ctrl.sv
// tb/tb_rtc_adj_ctrl.sv - directed bench for rtc_adj_ctrl with a cycle-level rtc model
module tb_rtc_adj_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_offset = 32'd0;
  logic [31:0] req_mark = 32'd0;
  logic        adj_ld_done = 1'b1;
  logic        req_ready, busy, done, adj_ld;
  logic [31:0] adj_ld_data;
  logic [39:0] period_adj;
`ifdef RTC_ADJ_CTRL_ACC_EN
  logic [31:0] applied_ns;
`endif

  rtc_adj_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_offset  (req_offset),
    .req_mark    (req_mark),
    .busy        (busy),
    .done        (done),
    .adj_ld      (adj_ld),
    .adj_ld_data (adj_ld_data),
    .period_adj  (period_adj),
    .adj_ld_done (adj_ld_done)
`ifdef RTC_ADJ_CTRL_ACC_EN
    ,
    .applied_ns  (applied_ns)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // rtc model: time advances 10 ns per edge plus the signed period_adj ns field on the apply edge
  int          cyc = 0;
  int          t_ld = -100;
  int          d_ld = 0;
  longint      rtc_time = 0;
  longint      ref_time = 0;
  longint      adj_v;
  int          ld_cnt = 0;
  int          done_cnt = 0;
  int          busy_cnt = 0;
  int          rdy_busy_cnt = 0;
  int          fin_cyc = 0;
  logic [39:0] ld_pa[$];
  logic [31:0] ld_data[$];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    ref_time <= ref_time + 10;
    adj_v = 0;
    if (cyc == t_ld + d_ld + 1) adj_v = longint'($signed(period_adj[39:32]));
    rtc_time <= rtc_time + 10 + adj_v;
    if (cyc == t_ld + 2) adj_ld_done <= 1'b0;
    if (cyc == t_ld + d_ld + 3) adj_ld_done <= 1'b1;
    if (adj_ld) begin
      t_ld   <= cyc;
      d_ld   <= int'(adj_ld_data);
      ld_cnt <= ld_cnt + 1;
      ld_pa.push_back(period_adj);
      ld_data.push_back(adj_ld_data);
    end
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  always @(negedge clk) begin
    if (done) fin_cyc <= cyc;
    if ((done && req_ready) || (busy && req_ready)) rdy_busy_cnt <= rdy_busy_cnt + 1;
  end

  int acc_cyc;

  task automatic send(input logic [31:0] off, input logic [31:0] mark, input bit keep);
    int n;
    n = 0;
    @(negedge clk);
    req_offset = off;
    req_mark   = mark;
    req_valid  = 1'b1;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("accept", {63'd0, req_ready}, 64'd1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic wait_ld(input int target);
    int n;
    n = 0;
    while (ld_cnt < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ld_reached", 64'(ld_cnt >= target), 64'd1);
  endtask

  task automatic wait_rtc_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!adj_ld_done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rtc_idle", {63'd0, adj_ld_done}, 64'd1);
  endtask

  int     b_ld, b_done, b_busy;
  longint b_off;
`ifdef RTC_ADJ_CTRL_ACC_EN
  logic [31:0] b_acc;
`endif

  task automatic snap();
    b_ld   = ld_cnt;
    b_done = done_cnt;
    b_busy = busy_cnt;
    b_off  = rtc_time - ref_time;
`ifdef RTC_ADJ_CTRL_ACC_EN
    b_acc  = applied_ns;
`endif
  endtask

  initial begin
    int fc;
    #1;
    check("rst_ready", {63'd0, req_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_adj_ld", {63'd0, adj_ld}, 64'd0);
    check("rst_ld_data", {32'd0, adj_ld_data}, 64'd0);
    check("rst_period", {24'd0, period_adj}, 64'd0);
`ifdef RTC_ADJ_CTRL_ACC_EN
    check("rst_applied", {32'd0, applied_ns}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {63'd0, req_ready}, 64'd1);

    // +10 in steps 4,4,2
    snap();
    send(32'd10, 32'd5, 1'b0);
    @(negedge clk);
    check("p10_adj_ld_n1", {63'd0, adj_ld}, 64'd1);
    check("p10_busy_n1", {63'd0, busy}, 64'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("p10_ld_cnt", 64'(ld_cnt - b_ld), 64'd3);
    check("p10_ns0", {56'd0, ld_pa[b_ld][39:32]}, 64'd4);
    check("p10_ns1", {56'd0, ld_pa[b_ld+1][39:32]}, 64'd4);
    check("p10_ns2", {56'd0, ld_pa[b_ld+2][39:32]}, 64'd2);
    check("p10_frac", {32'd0, ld_pa[b_ld+2][31:0]}, 64'd0);
    check("p10_data0", {32'd0, ld_data[b_ld]}, 64'd5);
    check("p10_data1", {32'd0, ld_data[b_ld+1]}, 64'd15);
    check("p10_data2", {32'd0, ld_data[b_ld+2]}, 64'd15);
    check("p10_done_cnt", 64'(done_cnt - b_done), 64'd1);
    check("p10_rtc_ahead", 64'(rtc_time - ref_time - b_off), 64'd10);
    check("p10_period_cleared", {24'd0, period_adj}, 64'd0);
`ifdef RTC_ADJ_CTRL_ACC_EN
    check("p10_applied", {32'd0, applied_ns - b_acc}, 64'd10);
`endif

    // -7 in steps -4,-3
    snap();
    send(-32'sd7, 32'd2, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    check("m7_ld_cnt", 64'(ld_cnt - b_ld), 64'd2);
    check("m7_pa0", {24'd0, ld_pa[b_ld]}, 64'hFC00000000);
    check("m7_pa1", {24'd0, ld_pa[b_ld+1]}, 64'hFD00000000);
    check("m7_rtc_behind", 64'(rtc_time - ref_time - b_off), 64'(-64'sd7));
`ifdef RTC_ADJ_CTRL_ACC_EN
    check("m7_applied", {32'd0, applied_ns - b_acc}, 64'hFFFFFFF9);
`endif

    // zero offset
    snap();
    send(32'd0, 32'd9, 1'b0);
    @(negedge clk);
    check("z_done_n1", {63'd0, done}, 64'd1);
    check("z_ready_n1", {63'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("z_ready_n2", {63'd0, req_ready}, 64'd1);
    repeat (2) @(negedge clk);
    check("z_no_ld", 64'(ld_cnt - b_ld), 64'd0);
    check("z_busy_cycles", 64'(busy_cnt - b_busy), 64'd1);
    check("z_done_cnt", 64'(done_cnt - b_done), 64'd1);

    // back-to-back with req_valid held
    snap();
    send(32'd3, 32'd2, 1'b1);
    send(32'd1, 32'd2, 1'b0);
    fc = fin_cyc;
    check("b2b_accept_after_fin", 64'(acc_cyc - fc), 64'd1);
    wait_done();
    repeat (3) @(negedge clk);
    check("b2b_ld_cnt", 64'(ld_cnt - b_ld), 64'd2);
    check("b2b_done_cnt", 64'(done_cnt - b_done), 64'd2);
    check("b2b_ns_second", {56'd0, ld_pa[b_ld+1][39:32]}, 64'd1);
    check("ready_never_with_busy", 64'(rdy_busy_cnt), 64'd0);

    // reset in WAIT_HIGH of step 2 of +12
    snap();
    send(32'd12, 32'd3, 1'b0);
    wait_ld(b_ld + 2);
    repeat (5) @(negedge clk);
    check("rst_mid_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", {63'd0, req_ready}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_adj_ld", {63'd0, adj_ld}, 64'd0);
    check("rst_mid_data", {32'd0, adj_ld_data}, 64'd0);
    check("rst_mid_period", {24'd0, period_adj}, 64'd0);
`ifdef RTC_ADJ_CTRL_ACC_EN
    check("rst_mid_applied", {32'd0, applied_ns}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_rtc_idle();
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt - b_done), 64'd0);
    check("rst_mid_no_more_ld", 64'(ld_cnt - b_ld), 64'd2);
    send(32'd4, 32'd2, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    check("after_rst_ld_cnt", 64'(ld_cnt - b_ld), 64'd3);
    check("after_rst_ns", {56'd0, ld_pa[b_ld+2][39:32]}, 64'd4);
    check("after_rst_done_cnt", 64'(done_cnt - b_done), 64'd1);
`ifdef RTC_ADJ_CTRL_ACC_EN
    check("after_rst_applied", {32'd0, applied_ns}, 64'd4);
`endif

    // -2^31: magnitude must be 2^31, first steps are full negative steps
    snap();
    send(32'h80000000, 32'd1, 1'b0);
    wait_ld(b_ld + 2);
    @(negedge clk);
    check("min_ns0", {56'd0, ld_pa[b_ld][39:32]}, 64'hFC);
    check("min_ns1", {56'd0, ld_pa[b_ld+1][39:32]}, 64'hFC);
    check("min_busy", {63'd0, busy}, 64'd1);
    check("min_no_done", 64'(done_cnt - b_done), 64'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_rtc_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
